// File: rtl/ram_be_clr.sv
// Single-port synchronous RAM with byte-lane write enables, a registered read
// port with a one-cycle valid pulse, selectable read-during-write behaviour and
// a clear sequencer that sweeps zeros through the whole array.
module ram_be_clr #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write_en,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    input  logic                      read_en,
    input  logic [ADDR_WIDTH-1:0]     adr,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      clear,
    output logic                      ready,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = {ADDR_WIDTH{1'b1}};

    // Array contents are deliberately outside the reset domain.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_adr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] merged;

    assign rd_word = mem[adr];

    // Merge the enabled byte lanes of din over the currently stored word.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // State, sweep counter and output registers; reset leaves the array alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RST_STATE;
            cnt_q        <= '0;
            ready_q      <= (CLEAR_ON_RESET == 0);
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Next state: sweep until the last address is written, clear request restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADR) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: array port control and registered read data; clear beats reads/writes.
    always_comb begin
        mem_we       = 1'b0;
        mem_adr      = adr;
        mem_wdata    = merged;
        ready_d      = (state_d == S_IDLE);
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_adr   = cnt_q;
                mem_wdata = '0;
            end
            S_IDLE: begin
                if (!clear) begin
                    mem_we = write_en;
                    if (read_en) begin
                        dout_d       = ((READ_MODE != 0) && write_en) ? merged : rd_word;
                        dout_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Single write port into the array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr] <= mem_wdata;
        end
    end

    assign ready      = ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ram_be_clr.sv
// Bench for ram_be_clr: three instances (read-first with clear-on-reset,
// write-first with clear-on-reset, read-first without) share one stimulus and
// are each checked every cycle against a word-array model, plus literal checks.
module tb_ram_be_clr;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic [3:0]  byte_en;
    logic        read_en;
    logic [5:0]  adr;
    logic [31:0] din;
    logic        clear;

    logic [2:0]  rdy_w;
    logic [2:0]  vld_w;
    logic [31:0] dout_w [3];

    int total  = 0;
    int passed = 0;

    localparam int RM  [3] = '{0, 1, 0};
    localparam int COR [3] = '{1, 1, 0};

    always #5 clk = ~clk;

    ram_be_clr #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset(reset), .write_en(write_en), .byte_en(byte_en), .read_en(read_en),
        .adr(adr), .din(din), .clear(clear), .ready(rdy_w[0]), .dout(dout_w[0]), .dout_valid(vld_w[0]));
    ram_be_clr #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset(reset), .write_en(write_en), .byte_en(byte_en), .read_en(read_en),
        .adr(adr), .din(din), .clear(clear), .ready(rdy_w[1]), .dout(dout_w[1]), .dout_valid(vld_w[1]));
    ram_be_clr #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .reset(reset), .write_en(write_en), .byte_en(byte_en), .read_en(read_en),
        .adr(adr), .din(din), .clear(clear), .ready(rdy_w[2]), .dout(dout_w[2]), .dout_valid(vld_w[2]));

    // Behavioural model: words, a "busy cycles remaining" count, expected outputs.
    logic [31:0] mmem   [3][64];
    bit          mknown [3][64];
    int          mbusy  [3];
    logic [31:0] mdout  [3];
    bit          mvld   [3];
    bit          mdknown[3];

    initial begin
        for (int m = 0; m < 3; m++)
            for (int a = 0; a < 64; a++) begin
                mmem[m][a]   = 32'h0;
                mknown[m][a] = 1'b0;
            end
    end

    always @(posedge clk or posedge reset) begin
        for (int m = 0; m < 3; m++) begin
            if (reset) begin
                mbusy[m]   = (COR[m] != 0) ? 64 : 0;
                mdout[m]   = 32'h0;
                mvld[m]    = 1'b0;
                mdknown[m] = 1'b1;
            end else if (mbusy[m] > 0) begin
                mmem[m][64 - mbusy[m]]   = 32'h0;
                mknown[m][64 - mbusy[m]] = 1'b1;
                mbusy[m]                 = mbusy[m] - 1;
                mvld[m]                  = 1'b0;
            end else if (clear) begin
                mbusy[m] = 64;
                mvld[m]  = 1'b0;
            end else begin
                logic [31:0] oldw, neww;
                bit          oldk, newk;
                oldw = mmem[m][adr];
                oldk = mknown[m][adr];
                neww = oldw;
                for (int i = 0; i < 4; i++)
                    if (write_en && byte_en[i]) neww[8*i +: 8] = din[8*i +: 8];
                newk = oldk || (write_en && byte_en == 4'hF);
                if (write_en) begin
                    mmem[m][adr]   = neww;
                    mknown[m][adr] = newk;
                end
                if (read_en) begin
                    mdout[m]   = (RM[m] != 0 && write_en) ? neww : oldw;
                    mdknown[m] = (RM[m] != 0 && write_en) ? newk : oldk;
                    mvld[m]    = 1'b1;
                end else begin
                    mvld[m] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("ready[%0d]", m), {31'h0, rdy_w[m]}, {31'h0, mbusy[m] == 0});
            chk($sformatf("dout_valid[%0d]", m), {31'h0, vld_w[m]}, {31'h0, mvld[m]});
            if (mdknown[m]) chk($sformatf("dout[%0d]", m), dout_w[m], mdout[m]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en = 1'b0; byte_en = 4'h0; read_en = 1'b0;
        adr = 6'd0; din = 32'h0; clear = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        idle(); write_en = 1'b1; adr = a; din = d; byte_en = be; step(); idle();
    endtask

    task automatic rd(input logic [5:0] a);
        idle(); read_en = 1'b1; adr = a; step(); idle();
    endtask

    // Counts rising edges until dut0 reports ready, bounded.
    task automatic edges_to_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!rdy_w[0] && n < 200);
    endtask

    int n;

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        chk("rst ready0", {31'h0, rdy_w[0]}, 32'h0);
        chk("rst ready2", {31'h0, rdy_w[2]}, 32'h1);
        chk("rst dout0", dout_w[0], 32'h0);
        chk("rst valid0", {31'h0, vld_w[0]}, 32'h0);
        reset = 1'b0;
        edges_to_ready(n);
        chk("reset sweep length", n, 64);

        for (int a = 0; a < 64; a++) rd(6'(a));
        chk("last zero read dout0", dout_w[0], 32'h0);
        chk("last zero read valid0", {31'h0, vld_w[0]}, 32'h1);

        wr(6'd5, 32'hAABBCCDD, 4'hF);
        wr(6'd5, 32'h11223344, 4'b0101);
        rd(6'd5);
        chk("byte merge dut0", dout_w[0], 32'hAA22CC44);
        chk("byte merge dut2", dout_w[2], 32'hAA22CC44);
        wr(6'd5, 32'h99999999, 4'h0);
        rd(6'd5);
        chk("byte_en 0 no change", dout_w[1], 32'hAA22CC44);

        wr(6'd9, 32'h0000FFFF, 4'hF);
        idle(); write_en = 1'b1; read_en = 1'b1; adr = 6'd9; din = 32'h12345678; byte_en = 4'hF;
        step(); idle();
        chk("rdw read-first", dout_w[0], 32'h0000FFFF);
        chk("rdw write-first", dout_w[1], 32'h12345678);
        rd(6'd9);
        chk("rdw after mode0", dout_w[0], 32'h12345678);
        chk("rdw after mode1", dout_w[1], 32'h12345678);

        wr(6'd3, 32'h11111111, 4'hF);
        idle(); clear = 1'b1; write_en = 1'b1; adr = 6'd3; din = 32'hDEADBEEF; byte_en = 4'hF;
        step(); idle();
        write_en = 1'b1; read_en = 1'b1; clear = 1'b1; adr = 6'd7; din = 32'h55555555; byte_en = 4'hF;
        edges_to_ready(n);
        idle();
        chk("clear sweep length", n, 64);
        rd(6'd3);
        chk("adr3 after clear", dout_w[0], 32'h0);
        rd(6'd7);
        chk("adr7 after clear dut2", dout_w[2], 32'h0);

        wr(6'd10, 32'hCAFEF00D, 4'hF);
        rd(6'd10);
        chk("pre-reset read", dout_w[0], 32'hCAFEF00D);
        idle(); clear = 1'b1; step(); idle();
        for (int i = 0; i < 20; i++) step();
        #2 reset = 1'b1;
        #1;
        chk("async dout0", dout_w[0], 32'h0);
        chk("async dout2", dout_w[2], 32'h0);
        chk("async valid0", {31'h0, vld_w[0]}, 32'h0);
        chk("async ready2", {31'h0, rdy_w[2]}, 32'h1);
        step();
        reset = 1'b0;
        edges_to_ready(n);
        chk("restart sweep length", n, 64);

        for (int i = 0; i < 4; i++) wr(6'(i), 32'(i + 1), 4'hF);
        idle(); read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            adr = 6'(i);
            step();
            chk($sformatf("b2b dut2 adr%0d", i), dout_w[2], 32'(i + 1));
            chk($sformatf("b2b valid adr%0d", i), {31'h0, vld_w[2]}, 32'h1);
        end
        idle();
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
